// File: rtl/led_frame_streamer_pkg.sv
// led_pkg: colour width, colour type, FSM state encoding and blank colour shared by the LED frame streamer
package led_pkg;
   localparam int LED_COLOR_W = 24;
   typedef logic [LED_COLOR_W-1:0] color_t;
   typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, GAP = 2'd2} state_e;
   localparam color_t COLOR_OFF = '0;
endpackage

// File: rtl/led_frame_streamer_if.sv
// led_frame_streamer_if: valid/ready LED stream towards the addressable-LED serializer
interface led_frame_streamer_if #(
   parameter int COLOR_W = 24,
   parameter int IDX_W = 4
);
   logic               out_valid;
   logic               out_ready;
   logic [COLOR_W-1:0] out_color;
   logic [IDX_W-1:0]   out_index;
   logic               out_last;
   modport master(output out_valid, out_color, out_index, out_last, input out_ready);
   modport slave(input out_valid, out_color, out_index, out_last, output out_ready);
endinterface

// File: rtl/led_frame_streamer_priority_enc.sv
// led_priority_enc: lowest set index of a lit vector plus an any-set flag
module led_priority_enc #(
   parameter int N_LEDS = 11,
   parameter int IDX_W = $clog2(N_LEDS)
) (
   input  logic [N_LEDS-1:0] lit,
   output logic [IDX_W-1:0]  first_lit,
   output logic              any_lit
);
   // scan downwards so the lowest lit index is the last one written
   always_comb begin
      first_lit = '0;
      for (int i = N_LEDS - 1; i >= 0; i--)
         if (lit[i]) first_lit = IDX_W'(i);
   end
   assign any_lit = |lit;
endmodule

// File: rtl/led_frame_streamer.sv
// led_frame_streamer: double-buffered LED frame streamed over valid/ready; LED_FRAME_BRIGHTNESS_EN adds a brightness scaler
module led_frame_streamer
   import led_pkg::*;
#(
   parameter int N_LEDS = 11,
   parameter int COLOR_W = LED_COLOR_W,
   parameter int GAP_CYCLES = 64,
   parameter int IDX_W = $clog2(N_LEDS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                frame_load,
   input  logic [N_LEDS-1:0]   led_select,
   input  logic [COLOR_W-1:0]  load_color,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_addr,
   input  logic [COLOR_W-1:0]  wr_color,
   input  logic                commit,
   input  logic                start,
`ifdef LED_FRAME_BRIGHTNESS_EN
   input  logic [7:0]          brightness,
`endif
   led_frame_streamer_if.master out_if,
   output logic                busy,
   output logic                commit_pending,
   output logic [IDX_W-1:0]    first_lit,
   output logic                any_lit
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_STREAM = STREAM;
   localparam logic [1:0] S_GAP = GAP;
   localparam int CNT_W = $clog2(GAP_CYCLES + 1);
   logic [COLOR_W-1:0] shadow [N_LEDS];
   logic [COLOR_W-1:0] active [N_LEDS];
   logic [COLOR_W-1:0] cur_color;
   logic [N_LEDS-1:0]  lit;
   logic [1:0]         state;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   cnt;
   logic               pending;
   logic               valid;
   logic               last;
   logic               hs;
   logic               gap_done;
   assign valid = state == S_STREAM;
   assign last = idx == IDX_W'(N_LEDS - 1);
   assign hs = valid && out_if.out_ready;
   assign gap_done = state == S_GAP && cnt == '0;
   // shadow buffer: bulk load, with a same-cycle single-LED write taking priority; out-of-range addresses match nothing
   always_ff @(posedge clock or posedge reset)
      if (reset) shadow <= '{default: '0};
      else
         for (int i = 0; i < N_LEDS; i++)
            if (wr_en && wr_addr == IDX_W'(i)) shadow[i] <= wr_color;
            else if (frame_load) shadow[i] <= led_select[i] ? load_color : '0;
   // active buffer: copied at once in IDLE, otherwise held until the edge that leaves GAP
   always_ff @(posedge clock or posedge reset)
      if (reset) active <= '{default: '0};
      else if ((commit && state == S_IDLE) || (gap_done && (pending || commit))) active <= shadow;
   // sequencer: IDLE -> STREAM (one LED per handshake) -> GAP (latch time) -> IDLE
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= S_IDLE;
         idx <= '0;
         cnt <= '0;
         pending <= 1'b0;
      end else begin
         if (state == S_IDLE && start) state <= S_STREAM;
         if (state == S_IDLE) idx <= '0;
         if (hs) idx <= last ? '0 : idx + 1'b1;
         if (hs && last) state <= S_GAP;
         if (hs && last) cnt <= CNT_W'(GAP_CYCLES - 1);
         if (state == S_GAP) cnt <= gap_done ? cnt : cnt - 1'b1;
         if (gap_done) state <= S_IDLE;
         pending <= state != S_IDLE && !gap_done && (pending || commit);
      end
`ifdef LED_FRAME_BRIGHTNESS_EN
   logic [7:0] bright;
   // brightness is captured at start so a frame is never rescaled half-way
   always_ff @(posedge clock or posedge reset)
      if (reset) bright <= '0;
      else if (state == S_IDLE && start) bright <= brightness;
   // each 8-bit channel becomes (chan * bright) >> 8, truncated
   always_comb begin
      cur_color = active[idx];
      for (int c = 0; c < COLOR_W / 8; c++)
         cur_color[c*8 +: 8] = 8'((16'(active[idx][c*8 +: 8]) * 16'(bright)) >> 8);
   end
`else
   assign cur_color = active[idx];
`endif
   // lit flags come straight from the unscaled active frame
   always_comb begin
      lit = '0;
      for (int i = 0; i < N_LEDS; i++)
         lit[i] = active[i] != '0;
   end
   led_priority_enc #(.N_LEDS(N_LEDS), .IDX_W(IDX_W)) u_prio (
      .lit(lit),
      .first_lit(first_lit),
      .any_lit(any_lit)
   );
   assign out_if.out_valid = valid;
   assign out_if.out_index = idx;
   assign out_if.out_color = valid ? cur_color : COLOR_W'(COLOR_OFF);
   assign out_if.out_last = valid && last;
   assign busy = state != S_IDLE;
   assign commit_pending = pending;
endmodule

// File: tb/tb_led_frame_streamer.sv
// tb_led_frame_streamer: directed table-driven bench for led_frame_streamer (both LED_FRAME_BRIGHTNESS_EN builds)
`timescale 1ns/1ps
module tb_led_frame_streamer;
   localparam int N = 11;
   localparam int CW = 24;
   localparam int GAPC = 64;
   localparam int IW = 4;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic frame_load = 1'b0;
   logic [N-1:0] led_select = '0;
   logic [CW-1:0] load_color = '0;
   logic wr_en = 1'b0;
   logic [IW-1:0] wr_addr = '0;
   logic [CW-1:0] wr_color = '0;
   logic commit = 1'b0;
   logic start = 1'b0;
   logic busy, commit_pending, any_lit;
   logic [IW-1:0] first_lit;
`ifdef LED_FRAME_BRIGHTNESS_EN
   logic [7:0] brightness = 8'd255;
`endif
   int total = 0;
   int passed = 0;
   logic [CW-1:0] m_sh [N];
   logic [CW-1:0] m_act [N];
   logic m_pend = 1'b0;
   logic [7:0] m_br = 8'd255;
   typedef struct {
      logic fl; logic [N-1:0] sel; logic [CW-1:0] lc;
      logic we; logic [IW-1:0] wa; logic [CW-1:0] wc;
      logic cm; logic [IW-1:0] ef; logic ea;
   } vec_t;
   vec_t tv [9];
   led_frame_streamer_if #(.COLOR_W(CW), .IDX_W(IW)) sif ();
   led_frame_streamer dut (
      .clock(clock), .reset(reset), .frame_load(frame_load), .led_select(led_select),
      .load_color(load_color), .wr_en(wr_en), .wr_addr(wr_addr), .wr_color(wr_color),
      .commit(commit), .start(start),
`ifdef LED_FRAME_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .out_if(sif), .busy(busy), .commit_pending(commit_pending),
      .first_lit(first_lit), .any_lit(any_lit)
   );
   always #5 clock = ~clock;
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   function automatic logic [CW-1:0] shown(input logic [CW-1:0] c);
`ifdef LED_FRAME_BRIGHTNESS_EN
      logic [CW-1:0] r;
      for (int k = 0; k < CW / 8; k++) r[k*8 +: 8] = 8'((int'(c[k*8 +: 8]) * int'(m_br)) / 256);
      return r;
`else
      return c;
`endif
   endfunction
   task automatic drive(input vec_t v);
      logic [CW-1:0] nsh [N];
      frame_load = v.fl; led_select = v.sel; load_color = v.lc;
      wr_en = v.we; wr_addr = v.wa; wr_color = v.wc; commit = v.cm;
      for (int i = 0; i < N; i++) nsh[i] = (v.we && int'(v.wa) == i) ? v.wc : v.fl ? (v.sel[i] ? v.lc : '0) : m_sh[i];
      if (v.cm) m_act = m_sh;
      m_sh = nsh;
      tick();
      frame_load = 1'b0; wr_en = 1'b0; commit = 1'b0;
   endtask
   task automatic stream(input bit toggle, input bit mid, input bit cs);
      int k = 0;
      int c = 0;
      bit rdy;
      bit inj = 1'b0;
      start = 1'b1;
      commit = cs;
      if (cs) m_act = m_sh;
`ifdef LED_FRAME_BRIGHTNESS_EN
      m_br = brightness;
`endif
      tick();
      start = 1'b0; commit = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int cyc = 0; cyc < 100 && k < N; cyc++) begin
         rdy = toggle ? (cyc % 2 == 0) : 1'b1;
         sif.out_ready = rdy;
         chk("valid", sif.out_valid, 1);
         chk("index", sif.out_index, k);
         chk("color", sif.out_color, shown(m_act[k]));
         chk("last", sif.out_last, k == N - 1);
         if (mid && !inj && k == 5) begin
            wr_en = 1'b1; wr_addr = 4'd3; wr_color = 24'h0000FF; commit = 1'b1;
            m_sh[3] = 24'h0000FF; m_pend = 1'b1; inj = 1'b1;
            tick();
            wr_en = 1'b0; commit = 1'b0;
            chk("pending_set", commit_pending, 1);
         end else tick();
         if (rdy) k++;
      end
      sif.out_ready = 1'b0;
      chk("handshakes", k, N);
      chk("gap_valid", sif.out_valid, 0);
      for (int cyc = 0; cyc < 200 && busy; cyc++) begin
         start = cyc == 10;
         c++;
         tick();
         start = 1'b0;
      end
      chk("gap_len", c, GAPC);
      if (m_pend) m_act = m_sh;
      m_pend = 1'b0;
      chk("pending_clear", commit_pending, 0);
      tick();
      chk("start_ignored", busy, 0);
   endtask
   initial begin
      sif.out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_sh[i] = '0;
         m_act[i] = '0;
      end
      tick();
      chk("rst_valid", sif.out_valid, 0);
      chk("rst_color", sif.out_color, 0);
      chk("rst_any", any_lit, 0);
      tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_pending", commit_pending, 0);
      chk("rst_first", first_lit, 0);
      tv[0] = '{1, 11'h024, 24'h00FF00, 0, 4'd0, 24'h0, 0, 4'd0, 0};
      tv[1] = '{0, 11'h000, 24'h0, 0, 4'd0, 24'h0, 1, 4'd2, 1};
      tv[2] = '{0, 11'h000, 24'h0, 1, 4'd15, 24'hFFFFFF, 1, 4'd2, 1};
      tv[3] = '{0, 11'h000, 24'h0, 1, 4'd0, 24'h000001, 0, 4'd2, 1};
      tv[4] = '{0, 11'h000, 24'h0, 0, 4'd0, 24'h0, 1, 4'd0, 1};
      tv[5] = '{1, 11'h010, 24'hAAAAAA, 1, 4'd4, 24'h123456, 0, 4'd0, 1};
      tv[6] = '{0, 11'h000, 24'h0, 0, 4'd0, 24'h0, 1, 4'd4, 1};
      tv[7] = '{0, 11'h000, 24'h0, 1, 4'd1, 24'h0000FF, 1, 4'd4, 1};
      tv[8] = '{0, 11'h000, 24'h0, 0, 4'd0, 24'h0, 1, 4'd1, 1};
      for (int i = 0; i < 9; i++) begin
         drive(tv[i]);
         chk($sformatf("vec%0d_first", i), first_lit, tv[i].ef);
         chk($sformatf("vec%0d_any", i), any_lit, tv[i].ea);
         chk($sformatf("vec%0d_pending", i), commit_pending, 0);
      end
      chk("led4_wr_wins", m_act[4], 24'h123456);
      stream(1'b0, 1'b0, 1'b0);
      drive('{1, 11'h024, 24'h00FF00, 0, 4'd0, 24'h0, 1, 4'd0, 0});
      drive('{0, 11'h000, 24'h0, 0, 4'd0, 24'h0, 1, 4'd0, 0});
      chk("plan_first", first_lit, 2);
      chk("plan_any", any_lit, 1);
      stream(1'b0, 1'b0, 1'b0);
      stream(1'b1, 1'b1, 1'b0);
      chk("after_gap_first", first_lit, 2);
      stream(1'b0, 1'b0, 1'b0);
      drive('{0, 11'h000, 24'h0, 1, 4'd7, 24'h112233, 0, 4'd0, 0});
      stream(1'b0, 1'b0, 1'b1);
      chk("commit_start_led7", m_act[7], 24'h112233);
`ifdef LED_FRAME_BRIGHTNESS_EN
      brightness = 8'd128;
      drive('{1, 11'h7FF, 24'hFF8000, 0, 4'd0, 24'h0, 0, 4'd0, 0});
      drive('{0, 11'h000, 24'h0, 0, 4'd0, 24'h0, 1, 4'd0, 0});
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
`ifdef LED_FRAME_BRIGHTNESS_EN
      brightness = 8'd0;
      tick();
      chk("bright_scaled", sif.out_color, 24'h7F4000);
`endif
      sif.out_ready = 1'b1;
      tick();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("mid_valid", sif.out_valid, 1);
      chk("mid_pending", commit_pending, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", sif.out_valid, 0);
      chk("arst_any", any_lit, 0);
      chk("arst_busy", busy, 0);
      chk("arst_pending", commit_pending, 0);
      tick();
      reset = 1'b0;
      sif.out_ready = 1'b0;
      tick();
      chk("post_rst_first", first_lit, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
